// File: rtl/instr_fetch.sv
// Instruction fetch front-end. It drives pc into a combinational ROM and buffers
// each {pc, instruction} pair in a 2-entry FIFO for the decoder (valid/ready).
// It handles jump redirects with a flush, and a level-sensitive halt.
// Latency: the first word is valid 2 edges after reset release. Throughput is 1 word per cycle.
// Backpressure: when the FIFO is full and not popped, fetching stalls and pc holds.
// Optional macro IFETCH_BOUND_EN stops fetching after address PC_LIMIT and raises fetch_done.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   pc          (out)         ROM address
//   instruction (in)          ROM data for pc, same cycle
//   fetch_valid/_instr/_pc    FIFO head towards the decoder
//   fetch_ready (in)          decoder accepts the head
//   jump, jump_target (in)    redirect with flush
//   halt        (in)          level; suppresses new fetches
//   fetch_done  (out)         bound reached (tied 0 without IFETCH_BOUND_EN)
module instr_fetch #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned RESET_PC          = 0,
  parameter int unsigned PC_LIMIT          = 45
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
  output logic [PC_WIDTH-1:0]          fetch_pc,
  input  logic                         fetch_ready,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          jump_target,
  input  logic                         halt,
  output logic                         fetch_done
);

  // PC_LIMIT must name a real ROM word.
  if (PC_LIMIT > (1 << PC_WIDTH) - 1) begin : g_bad_limit
    $error("PC_LIMIT lies outside the ROM address range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [1:0]                   count_q, count_d;
  // Shift-style FIFO: the head is always entry 0, so outputs need no read mux.
  logic [INSTRUCTION_WIDTH-1:0] head_instr_q, head_instr_d;
  logic [PC_WIDTH-1:0]          head_pc_q, head_pc_d;
  logic [INSTRUCTION_WIDTH-1:0] tail_instr_q, tail_instr_d;
  logic [PC_WIDTH-1:0]          tail_pc_q, tail_pc_d;

  logic pop;
  logic space;
  logic push;
  logic redirect;
  logic bound_ok;

`ifdef IFETCH_BOUND_EN
  logic done_q, done_d;
  assign bound_ok   = !done_q;
  assign fetch_done = done_q;
`else
  assign bound_ok   = 1'b1;
  assign fetch_done = 1'b0;
`endif

  assign redirect = jump && (state_q != S_IDLE);
  assign pop      = (count_q != 2'd0) && fetch_ready;
  assign space    = (count_q < 2'd2) || pop;
  // The edge that first sees halt (or a redirect) already suppresses the push.
  assign push     = (state_q == S_RUN) && !halt && !redirect && space && bound_ok;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
`ifdef IFETCH_BOUND_EN
    done_d       = done_q;
`endif

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_STOP;
      S_STOP:  if (!halt) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      // Flush wins over any concurrent pop; the target is fetched next cycle.
      count_d = 2'd0;
      pc_d    = jump_target;
`ifdef IFETCH_BOUND_EN
      done_d  = (jump_target > PC_WIDTH'(PC_LIMIT));
`endif
    end else begin
      if (push) begin
`ifdef IFETCH_BOUND_EN
        if (pc_q == PC_WIDTH'(PC_LIMIT)) begin
          done_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
`else
        pc_d = pc_q + PC_WIDTH'(1);
`endif
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = instruction;
            head_pc_d    = pc_q;
          end else begin
            tail_instr_d = instruction;
            tail_pc_d    = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last word leaves the head untouched (holds last value).
          if (count_q == 2'd2) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = instruction;
            tail_pc_d    = pc_q;
          end else begin
            head_instr_d = instruction;
            head_pc_d    = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_WIDTH'(RESET_PC);
      count_q      <= 2'd0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
`ifdef IFETCH_BOUND_EN
      done_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
`ifdef IFETCH_BOUND_EN
      done_q       <= done_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (count_q != 2'd0);
  assign fetch_instr = head_instr_q;
  assign fetch_pc    = head_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. It uses a random ROM image and checks
// the accepted word stream against an address-sequence model: consecutive pcs from
// reset or a jump target, with data equal to rom[pc]. Directed timing checks are included.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] instruction;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic [7:0]  fetch_pc;
  logic        fetch_ready;
  logic        jump;
  logic [7:0]  jump_target;
  logic        halt;
  logic        fetch_done;

  logic [15:0] rom [256];
  logic [7:0]  exp_next;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign instruction = rom[pc];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .jump        (jump),
    .jump_target (jump_target),
    .halt        (halt),
    .fetch_done  (fetch_done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_ready = 1'b0; jump = 1'b0; jump_target = '0; halt = 1'b0;
    repeat (3) step;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fetch_done); end
    checks++; if (fetch_instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0000", fetch_instr); end
    checks++; if (fetch_pc !== 8'h00) begin errors++; $display("FAIL reset_fetch_pc: got %h want 00", fetch_pc); end
  endtask

  task automatic test_latency_stream;
    fetch_ready = 1'b1;
    rst = 1'b0;
    step;  // IDLE -> RUN edge
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid got %b want 0", fetch_valid); end
    step;  // first push edge
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL latency_first: valid got %b want 1", fetch_valid); end
    exp_next = 8'h00;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h want pc=%h instr=%h", i, fetch_valid, fetch_pc, fetch_instr, exp_next, rom[exp_next]);
      end
      exp_next++;
      step;
    end
  endtask

  task automatic test_backpressure;
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL stall_head[%0d]: valid=%b pc=%h instr=%h want pc=%h", i, fetch_valid, fetch_pc, fetch_instr, exp_next);
      end
    end
    checks++; if (pc !== exp_next + 8'd2) begin errors++; $display("FAIL stall_pc: got %h want %h", pc, exp_next + 8'd2); end
    fetch_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL resume[%0d]: valid=%b pc=%h instr=%h want pc=%h instr=%h", i, fetch_valid, fetch_pc, fetch_instr, exp_next, rom[exp_next]);
      end
      exp_next++;
      step;
    end
  endtask

  task automatic test_halt;
    logic [7:0] held_pc;
    int drained;
    fetch_ready = 1'b0;
    step; step;  // fill both entries
    held_pc = exp_next + 8'd2;
    halt = 1'b1; fetch_ready = 1'b1;
    drained = 0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_valid) begin
        checks++;
        if (fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
          errors++;
          $display("FAIL halt_drain[%0d]: pc=%h instr=%h want pc=%h", i, fetch_pc, fetch_instr, exp_next);
        end
        exp_next++;
        drained++;
      end
      step;
    end
    checks++; if (drained != 2) begin errors++; $display("FAIL halt_drain_count: got %0d want 2", drained); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_empty: valid got %b want 0", fetch_valid); end
    checks++; if (pc !== held_pc) begin errors++; $display("FAIL halt_pc: got %h want %h", pc, held_pc); end
    halt = 1'b0;
    step; step;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL halt_resume[%0d]: valid=%b pc=%h want pc=%h", i, fetch_valid, fetch_pc, exp_next);
      end
      exp_next++;
      step;
    end
  endtask

  task automatic test_jump;
    fetch_ready = 1'b0;
    step; step;  // FIFO full
    fetch_ready = 1'b1; jump = 1'b1; jump_target = 8'h20;
    step;
    jump = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL jump_flush: valid got %b want 0", fetch_valid); end
    checks++; if (pc !== 8'h20) begin errors++; $display("FAIL jump_pc: got %h want 20", pc); end
    exp_next = 8'h20;
    step;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL jump_stream[%0d]: valid=%b pc=%h want pc=%h", i, fetch_valid, fetch_pc, exp_next);
      end
      exp_next++;
      step;
    end
  endtask

  task automatic test_jump_in_stop;
    halt = 1'b1; fetch_ready = 1'b0;
    step; step;
    jump = 1'b1; jump_target = 8'h10;
    step;
    jump = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stop_jump_flush: valid got %b want 0", fetch_valid); end
    repeat (3) step;
    checks++; if (fetch_valid !== 1'b0 || pc !== 8'h10) begin errors++; $display("FAIL stop_jump_hold: valid=%b pc=%h want 0/10", fetch_valid, pc); end
    halt = 1'b0; fetch_ready = 1'b1;
    step; step;
    exp_next = 8'h10;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL stop_jump_stream[%0d]: valid=%b pc=%h want pc=%h", i, fetch_valid, fetch_pc, exp_next);
      end
      exp_next++;
      step;
    end
  endtask

`ifndef IFETCH_BOUND_EN
  task automatic test_wrap;
    fetch_ready = 1'b1; jump = 1'b1; jump_target = 8'hFE;
    step;
    jump = 1'b0;
    step;
    exp_next = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h want pc=%h", i, fetch_valid, fetch_pc, exp_next);
      end
      exp_next++;
      step;
    end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL wrap_done: got %b want 0", fetch_done); end
  endtask
`else
  task automatic test_bound;
    int got;
    fetch_ready = 1'b1; jump = 1'b1; jump_target = 8'hFE;
    step;
    jump = 1'b0;
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL bound_far_done: got %b want 1", fetch_done); end
    repeat (3) step;
    checks++; if (fetch_valid !== 1'b0 || pc !== 8'hFE) begin errors++; $display("FAIL bound_far_nopush: valid=%b pc=%h", fetch_valid, pc); end
    jump = 1'b1; jump_target = 8'd40;
    step;
    jump = 1'b0;
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL bound_clear: got %b want 0", fetch_done); end
    exp_next = 8'd40;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (fetch_valid) begin
        checks++;
        if (fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
          errors++;
          $display("FAIL bound_stream[%0d]: pc=%h want %h", i, fetch_pc, exp_next);
        end
        exp_next++;
        got++;
      end
      step;
    end
    checks++; if (got != 6) begin errors++; $display("FAIL bound_count: got %0d want 6", got); end
    checks++; if (fetch_done !== 1'b1 || pc !== 8'd45) begin errors++; $display("FAIL bound_stop: done=%b pc=%h want 1/2d", fetch_done, pc); end
    jump = 1'b1; jump_target = 8'h00;
    step;
    jump = 1'b0;
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL bound_rejump: done got %b want 0", fetch_done); end
    step;
    exp_next = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
        errors++;
        $display("FAIL bound_resume[%0d]: valid=%b pc=%h want %h", i, fetch_valid, fetch_pc, exp_next);
      end
      exp_next++;
      step;
    end
  endtask
`endif

  task automatic test_random;
    logic        prev_hold;
    logic [7:0]  prev_pc;
    logic [15:0] prev_instr;
    int          accepted;
    prev_hold = 1'b0; prev_pc = '0; prev_instr = '0; accepted = 0;
    halt = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      jump = ($urandom_range(0, 39) == 0);
`ifdef IFETCH_BOUND_EN
      jump_target = 8'($urandom_range(0, 50));
`else
      jump_target = 8'($urandom);
`endif
      if (prev_hold) begin
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== prev_pc || fetch_instr !== prev_instr) begin
          errors++;
          $display("FAIL rand_stable[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", i, fetch_valid, fetch_pc, fetch_instr, prev_pc, prev_instr);
        end
      end
      if (fetch_valid && fetch_ready && !jump) begin
        checks++;
        if (fetch_pc !== exp_next || fetch_instr !== rom[exp_next]) begin
          errors++;
          $display("FAIL rand_accept[%0d]: pc=%h instr=%h want pc=%h instr=%h", i, fetch_pc, fetch_instr, exp_next, rom[exp_next]);
        end
        exp_next++;
        accepted++;
      end
      if (jump) exp_next = jump_target;
      prev_hold  = fetch_valid && !fetch_ready && !jump;
      prev_pc    = fetch_pc;
      prev_instr = fetch_instr;
      step;
    end
    jump = 1'b0; halt = 1'b0;
    checks++; if (accepted < 50) begin errors++; $display("FAIL rand_progress: accepted %0d want >= 50", accepted); end
  endtask

  task automatic test_mid_reset;
    halt = 1'b0; fetch_ready = 1'b0; jump = 1'b1; jump_target = 8'h05;
    step;
    jump = 1'b0;
    repeat (3) step;  // two words buffered
    rst = 1'b1;
    step;
    checks++; if (fetch_valid !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL midreset: valid=%b pc=%h want 0/00", fetch_valid, pc); end
    rst = 1'b0; fetch_ready = 1'b1;
    step;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: valid got %b want 0", fetch_valid); end
    step;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h00 || fetch_instr !== rom[0]) begin errors++; $display("FAIL midreset_first: valid=%b pc=%h want 1/00", fetch_valid, fetch_pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    test_reset;
    test_latency_stream;
    test_backpressure;
    test_halt;
    test_jump;
    test_jump_in_stop;
`ifndef IFETCH_BOUND_EN
    test_wrap;
`else
    test_bound;
`endif
    test_random;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Sequential fetch front-end that drives the `pc` address into the combinational instruction ROM and captures the returned `instruction` word.
- Buffers fetched words in a 2-entry FIFO and presents them to the decoder with a valid/ready handshake.
- Handles jump redirects with a flush, and a level-sensitive halt.
- Sits between the instruction memory and the decode/execute stage.

Parameters:
- PC_WIDTH, 8, width of the program counter and ROM address (256-word ROM).
- INSTRUCTION_WIDTH, 16, width of one instruction word.
- RESET_PC, 0, first address fetched after reset.
- PC_LIMIT, 45, last valid ROM address; used only with IFETCH_BOUND_EN.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- pc  output  PC_WIDTH  address to instruction ROM
- instruction  input  INSTRUCTION_WIDTH  ROM read data, combinational from pc, same cycle
- fetch_valid  output  1  FIFO head holds a valid instruction
- fetch_instr  output  INSTRUCTION_WIDTH  instruction at FIFO head
- fetch_pc  output  PC_WIDTH  address the head instruction was fetched from
- fetch_ready  input  1  decoder accepts head this cycle when fetch_valid=1
- jump  input  1  redirect request, single-cycle pulse
- jump_target  input  PC_WIDTH  redirect address, sampled when jump=1
- halt  input  1  level: suppress new fetches while high
- fetch_done  output  1  bound reached (IFETCH_BOUND_EN only; otherwise tied 0)

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, FIFO empty (count=0), fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_done=0, state=IDLE.
  - Reset mid-operation discards all buffered words.
- States:
  - IDLE: entered only from reset; goes to RUN on the next edge. No push in IDLE.
  - RUN → STOP when halt=1.
  - STOP → RUN when halt=0.
  - jump is honoured in any state except IDLE.
- Push: a push occurs in RUN when `space = (count<2) || pop`. {pc, instruction} enters the FIFO tail and pc <= pc+1, modulo 2^PC_WIDTH (0xFF wraps to 0x00).
- Pop: a pop occurs when fetch_valid && fetch_ready; the head advances.
- Push and pop in the same cycle: count is unchanged, including when full.
- Full (count=2) and no pop: no push, pc is held.
- Empty: fetch_valid=0; fetch_instr/fetch_pc hold their last values. They are don't-care for verification.
- Latency: the first word is valid at the 2nd edge after rst falls (IDLE edge, then push edge); fetch_valid is high in the following cycle.
- Sustained throughput is 1 instr/cycle with fetch_ready held high.
- Jump (highest priority):
  - At the edge: FIFO flushed (count=0), pc <= jump_target, no push, and any concurrent pop is discarded.
  - fetch_valid=0 in the cycle after the jump edge; the target word is valid one cycle later.
  - jump during STOP: redirect and flush still occur; fetching resumes at jump_target when halt falls.
- halt asserted: no push from the same edge onward; pc holds; buffered words still drain through the handshake.
- Handshake rules:
  - fetch_instr/fetch_pc are stable while fetch_valid=1 and fetch_ready=0.
  - fetch_valid never drops without a pop, jump or reset.

Optional Feature:
IFETCH_BOUND_EN
- Defined:
  - Once the word at pc==PC_LIMIT is pushed, fetching stops and pc holds at PC_LIMIT.
  - fetch_done is asserted (sticky) from the following cycle.
  - Buffered words still drain.
  - A jump clears fetch_done and resumes fetching at jump_target; a jump to a target >PC_LIMIT sets fetch_done immediately with no push.
- Undefined: fetch_done is tied 0; pc wraps modulo 2^PC_WIDTH; no bound check logic is present.

Test Plan:
- Reset release, ROM[i]=16'h1000+i, fetch_ready=1 → fetch_valid rises 2 cycles after rst falls; decoder receives 1000,1001,1002… with fetch_pc 0,1,2…, one per cycle.
- fetch_ready=0 for 5 cycles from pc=3 → FIFO fills with words 3,4; pc holds at 5; head stays 1003. Then ready=1 → 1003,1004,1005 arrive with no gap or duplicate.
- jump=1, jump_target=8'h20 while FIFO holds 2 words and ready=1 → both words flushed, fetch_valid=0 for 1 cycle, next accepted word is ROM[0x20] with fetch_pc=0x20.
- halt=1 with 2 buffered words, ready=1 → exactly 2 words drain, then fetch_valid=0, pc constant. halt=0 → fetching resumes at held pc.
- Start at jump_target=8'hFE → fetch_pc sequence FE,FF,00,01 (wrap, macro undefined).
- IFETCH_BOUND_EN, PC_LIMIT=45 → last word has fetch_pc=45; fetch_done=1 afterwards. jump to 0 → fetch_done=0 and words from 0 resume.
